// File: rtl/mem_arbiter.sv
// Shares one multicycle memory port between the I-side and D-side miss paths:
// D-priority grant, WORDS-beat block fills and single-word D writes.
module mem_arbiter #(
  parameter int WORDS  = 8,
  parameter int ADDR_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_req,
  input  logic [ADDR_W-1:0]        i_addr,
  input  logic                     d_req,
  input  logic                     d_we,
  input  logic [ADDR_W-1:0]        d_addr,
  input  logic [15:0]              d_wdata,
  input  logic [15:0]              mem_rdata,
  input  logic                     mem_rvalid,
  output logic                     mem_en,
  output logic                     mem_wr,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [15:0]              mem_wdata,
  output logic [15:0]              fill_data,
  output logic                     i_fill_valid,
  output logic                     d_fill_valid,
  output logic [$clog2(WORDS)-1:0] fill_idx,
  output logic                     i_busy,
  output logic                     d_busy,
  output logic                     i_done,
  output logic                     d_done
);

  localparam int IW = $clog2(WORDS);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_IFILL  = 2'd1;
  localparam logic [1:0] S_DFILL  = 2'd2;
  localparam logic [1:0] S_DWRITE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [IW:0]       iss_q, iss_d;   // top bit marks "all words issued"
  logic [IW-1:0]     ret_q, ret_d;
  logic              i_done_q, i_done_d, d_done_q, d_done_d;
  logic [ADDR_W-1:0] base;

  assign base = addr_q & ~ADDR_W'(2 * WORDS - 1);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    iss_d        = iss_q;
    ret_d        = ret_q;
    i_done_d     = 1'b0;
    d_done_d     = 1'b0;
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    fill_data    = '0;
    i_fill_valid = 1'b0;
    d_fill_valid = 1'b0;
    fill_idx     = '0;
    unique case (state_q)
      S_IDLE: begin
        iss_d = '0;
        ret_d = '0;
        // The done cycle is a bubble so a still-held request is not re-granted.
        if (!i_done_q && !d_done_q) begin
          if (d_req) begin
            state_d = d_we ? S_DWRITE : S_DFILL;
            addr_d  = d_addr;
            wdata_d = d_wdata;
          end else if (i_req) begin
            state_d = S_IFILL;
            addr_d  = i_addr;
          end
        end
      end
      S_IFILL, S_DFILL: begin
        if (!iss_q[IW]) begin
          mem_en   = 1'b1;
          mem_addr = base + ADDR_W'({iss_q[IW-1:0], 1'b0});
          iss_d    = iss_q + 1'b1;
        end
        if (mem_rvalid) begin
          fill_data    = mem_rdata;
          fill_idx     = ret_q;
          i_fill_valid = (state_q == S_IFILL);
          d_fill_valid = (state_q == S_DFILL);
          ret_d        = ret_q + 1'b1;
          if (ret_q == IW'(WORDS - 1)) begin
            state_d  = S_IDLE;
            iss_d    = '0;
            i_done_d = (state_q == S_IFILL);
            d_done_d = (state_q == S_DFILL);
          end
        end
      end
      S_DWRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        state_d   = S_IDLE;
        d_done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign i_busy = (state_q == S_IFILL);
  assign d_busy = (state_q == S_DFILL) || (state_q == S_DWRITE);
  assign i_done = i_done_q;
  assign d_done = d_done_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      iss_q    <= '0;
      ret_q    <= '0;
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      iss_q    <= iss_d;
      ret_q    <= ret_d;
      i_done_q <= i_done_d;
      d_done_q <= d_done_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: transaction-level model checked every cycle,
// plus a table of hand-computed expectations for the reference scenarios.
module tb_mem_arbiter;
  localparam int WORDS = 8;
  localparam int IW    = 3;

  logic clk = 1'b0, rst_n = 1'b0;
  logic i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic [15:0] mem_rdata = '0;
  logic mem_rvalid = 1'b0;
  logic mem_en, mem_wr, i_fill_valid, d_fill_valid, i_busy, d_busy, i_done, d_done;
  logic [15:0] mem_addr, mem_wdata, fill_data;
  logic [IW-1:0] fill_idx;

  mem_arbiter #(.WORDS(WORDS), .ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_addr(i_addr), .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .fill_data(fill_data), .i_fill_valid(i_fill_valid), .d_fill_valid(d_fill_valid),
    .fill_idx(fill_idx), .i_busy(i_busy), .d_busy(d_busy), .i_done(i_done), .d_done(d_done));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory: fixed-latency pipelined reads, random junk on rdata when idle.
  int lat = 4;
  logic        pv [64];
  logic [15:0] pd [64];
  initial for (int i = 0; i < 64; i++) pv[i] = 1'b0;
  always begin
    @(negedge clk);
    if (mem_en === 1'b1 && mem_wr === 1'b0) begin
      pv[(cyc + lat) % 64] = 1'b1;
      pd[(cyc + lat) % 64] = 16'($urandom);
    end
    @(posedge clk);
    #1;
    mem_rvalid = pv[cyc % 64];
    mem_rdata  = pv[cyc % 64] ? pd[cyc % 64] : 16'($urandom);
    pv[cyc % 64] = 1'b0;
  end

  // Literal expectation table, filled by the stimulus, consumed by the checker.
  localparam int L_EN = 0, L_WR = 1, L_ADDR = 2, L_WDATA = 3, L_IFV = 4, L_IDX = 5,
                 L_IDONE = 6, L_DDONE = 7, L_IBUSY = 8, L_DBUSY = 9;
  typedef struct { int cyc; int id; logic [31:0] val; } lit_t;
  lit_t lit_tab [256];
  int   lit_n = 0;
  logic timeout_flag = 1'b0;

  function automatic logic [31:0] sig_val(input int id);
    case (id)
      L_EN:    return 32'(mem_en);
      L_WR:    return 32'(mem_wr);
      L_ADDR:  return 32'(mem_addr);
      L_WDATA: return 32'(mem_wdata);
      L_IFV:   return 32'(i_fill_valid);
      L_IDX:   return 32'(fill_idx);
      L_IDONE: return 32'(i_done);
      L_DDONE: return 32'(d_done);
      L_IBUSY: return 32'(i_busy);
      default: return 32'(d_busy);
    endcase
  endfunction

  // ---------------- checker + behavioural model ----------------
  int n_checks = 0, n_errs = 0, lit_ptr = 0;
  int m_op = 0;          // 0 none, 1 I fill, 2 D fill, 3 D write
  int m_iss = 0, m_ret = 0, m_done = 0;  // m_done: 0 none, 1 I, 2 D
  logic [15:0] m_addr = '0, m_wdata = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      if (n_errs <= 30) $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    bit fill, e_en, e_ifv, e_dfv;
    logic [15:0] e_addr;
    int nd;
    fill  = (m_op == 1) || (m_op == 2);
    e_en  = (fill && m_iss < WORDS) || (m_op == 3);
    e_addr = (m_op == 3) ? m_addr
           : e_en ? (m_addr & ~16'(2 * WORDS - 1)) + 16'(2 * m_iss) : 16'h0;
    e_ifv = (m_op == 1) && mem_rvalid;
    e_dfv = (m_op == 2) && mem_rvalid;
    if (cyc >= 2) begin
      chk("mem_en", 32'(mem_en), 32'(e_en));
      chk("mem_wr", 32'(mem_wr), 32'(m_op == 3));
      chk("mem_addr", 32'(mem_addr), 32'(e_addr));
      chk("mem_wdata", 32'(mem_wdata), (m_op == 3) ? 32'(m_wdata) : 32'h0);
      chk("i_fill_valid", 32'(i_fill_valid), 32'(e_ifv));
      chk("d_fill_valid", 32'(d_fill_valid), 32'(e_dfv));
      if (e_ifv || e_dfv) begin
        chk("fill_data", 32'(fill_data), 32'(mem_rdata));
        chk("fill_idx", 32'(fill_idx), 32'(m_ret % WORDS));
      end
      chk("i_busy", 32'(i_busy), 32'(m_op == 1));
      chk("d_busy", 32'(d_busy), 32'(m_op >= 2));
      chk("i_done", 32'(i_done), 32'(m_done == 1));
      chk("d_done", 32'(d_done), 32'(m_done == 2));
      chk("wait_timeout", 32'(timeout_flag), 32'h0);
    end
    while (lit_ptr < lit_n && lit_tab[lit_ptr].cyc <= cyc) begin
      if (lit_tab[lit_ptr].cyc == cyc)
        chk($sformatf("lit_id%0d", lit_tab[lit_ptr].id), sig_val(lit_tab[lit_ptr].id), lit_tab[lit_ptr].val);
      else
        chk("lit_missed", 32'h1, 32'h0);
      lit_ptr++;
    end
    // Advance the model to the next cycle.
    if (!rst_n) begin
      m_op = 0; m_done = 0; m_iss = 0; m_ret = 0;
    end else begin
      nd = 0;
      if (fill) begin
        if (e_en) m_iss++;
        if (mem_rvalid) begin
          m_ret++;
          if (m_ret == WORDS) begin nd = m_op; m_op = 0; end
        end
      end else if (m_op == 3) begin
        m_op = 0; nd = 2;
      end else if (m_done == 0) begin
        m_iss = 0; m_ret = 0;
        if (d_req) begin
          m_op = d_we ? 3 : 2; m_addr = d_addr; m_wdata = d_wdata;
        end else if (i_req) begin
          m_op = 1; m_addr = i_addr;
        end
      end
      m_done = nd;
    end
  end

  // ---------------- stimulus ----------------
  int c0 = 0;

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_scn();
    next_cyc();
    c0 = cyc;
  endtask

  task automatic wait_rel(input int n);
    while (cyc < c0 + n) next_cyc();
    @(negedge clk);
  endtask

  task automatic lit(input int rel, input int id, input logic [31:0] v);
    lit_tab[lit_n] = '{cyc: c0 + rel, id: id, val: v};
    lit_n++;
  endtask

  task automatic quiesce();
    int n;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; rst_n = 1'b1;
    n = 0;
    while ((i_busy || d_busy) && n < 60) begin next_cyc(); n++; end
    if (n >= 60) timeout_flag = 1'b1;
    for (int k = 0; k < lat + 4; k++) next_cyc();
  endtask

  initial begin
    lat = 4;
    next_cyc(); next_cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) next_cyc();

    // I fill of block 0x0120
    start_scn();
    i_req = 1'b1; i_addr = 16'h012A;
    lit(1, L_EN, 1); lit(1, L_ADDR, 16'h0120); lit(4, L_IFV, 0); lit(5, L_IFV, 1);
    lit(5, L_IDX, 0); lit(8, L_ADDR, 16'h012E); lit(9, L_EN, 0); lit(12, L_IFV, 1);
    lit(12, L_IDX, 7); lit(12, L_IDONE, 0); lit(12, L_IBUSY, 1); lit(13, L_IDONE, 1);
    lit(13, L_IBUSY, 0); lit(14, L_IDONE, 0);
    wait_rel(13); next_cyc(); i_req = 1'b0;
    for (int k = 0; k < 3; k++) next_cyc();

    // Simultaneous requests: D fill first, then I
    start_scn();
    i_req = 1'b1; i_addr = 16'h0200; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h4000;
    lit(1, L_DBUSY, 1); lit(1, L_IBUSY, 0); lit(1, L_ADDR, 16'h4000); lit(13, L_DDONE, 1);
    lit(14, L_DBUSY, 0); lit(14, L_IBUSY, 0); lit(15, L_IBUSY, 1); lit(15, L_ADDR, 16'h0200);
    lit(27, L_IDONE, 1);
    wait_rel(13); next_cyc(); d_req = 1'b0;
    wait_rel(27); next_cyc(); i_req = 1'b0;
    for (int k = 0; k < 3; k++) next_cyc();

    // D write, request held through the done cycle
    start_scn();
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0036; d_wdata = 16'hBEEF;
    lit(1, L_EN, 1); lit(1, L_WR, 1); lit(1, L_ADDR, 16'h0036); lit(1, L_WDATA, 16'hBEEF);
    lit(2, L_DDONE, 1); lit(2, L_EN, 0); lit(2, L_WDATA, 0); lit(2, L_DBUSY, 0);
    lit(3, L_DBUSY, 0); lit(3, L_EN, 0);
    wait_rel(2); next_cyc(); d_req = 1'b0; d_we = 1'b0;
    for (int k = 0; k < 3; k++) next_cyc();

    // Reset in the middle of an I fill
    start_scn();
    i_req = 1'b1; i_addr = 16'h012A;
    lit(4, L_EN, 1); lit(5, L_EN, 0); lit(5, L_IBUSY, 0); lit(5, L_ADDR, 0);
    lit(6, L_IFV, 0); lit(8, L_IFV, 0); lit(13, L_IDONE, 0);
    wait_rel(3); next_cyc(); rst_n = 1'b0; i_req = 1'b0;
    next_cyc(); rst_n = 1'b1;
    wait_rel(14);
    next_cyc();

    // Request dropped mid-fill with a new address
    start_scn();
    i_req = 1'b1; i_addr = 16'h012A;
    lit(3, L_ADDR, 16'h0124); lit(8, L_ADDR, 16'h012E); lit(13, L_IDONE, 1);
    lit(14, L_IBUSY, 0); lit(15, L_IBUSY, 0);
    wait_rel(2); next_cyc(); i_req = 1'b0; i_addr = 16'h0F00;
    wait_rel(16);

    // Random traffic in segments, each with its own memory latency
    for (int seg = 0; seg < 3; seg++) begin
      quiesce();
      lat = $urandom_range(1, 6);
      for (int k = 0; k < 1200; k++) begin
        next_cyc();
        if (!rst_n) rst_n = 1'b1;
        else if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
        if (!i_req) begin
          if ($urandom_range(0, 7) == 0) begin i_req = 1'b1; i_addr = 16'($urandom); end
        end else if (i_done) begin
          if ($urandom_range(0, 1) == 0) i_req = 1'b0;
        end else if ($urandom_range(0, 63) == 0) i_req = 1'b0;
        if ($urandom_range(0, 3) == 0) i_addr = 16'($urandom);
        if (!d_req) begin
          if ($urandom_range(0, 9) == 0) begin
            d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
            d_addr = 16'($urandom); d_wdata = 16'($urandom);
          end
        end else if (d_done) begin
          if ($urandom_range(0, 1) == 0) d_req = 1'b0;
        end else if ($urandom_range(0, 63) == 0) d_req = 1'b0;
        if ($urandom_range(0, 3) == 0) begin d_addr = 16'($urandom); d_wdata = 16'($urandom); end
      end
    end
    quiesce();
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1);
  end
endmodule
